// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit that sits beside the single-cycle ALU and
//   owns the HI/LO register pair. MULT/MULTU/DIV/DIVU take WIDTH+1 cycles
//   (WIDTH iterations plus one sign-fix cycle) under a Start/Busy/Done
//   handshake. MTHI/MTLO complete in a single cycle without raising Busy.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high; aborts any operation in flight
//   Start    request, sampled only while idle
//   MdOp     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   DataIn1  multiplicand / dividend / MTHI-MTLO source
//   DataIn2  multiplier / divisor
//   Busy     high while an iterative operation is in flight
//   Done     one-cycle pulse once Hi/Lo hold a new result
//   Hi, Lo   result registers (product high/low, remainder/quotient)
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       MdOp,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

  stateT            stateReg, stateNext;
  logic [CW-1:0]    countReg;
  logic             isDivReg;
  logic             negAReg, negBReg;
  logic             divZeroReg;
  logic [WIDTH-1:0] srcAReg;     // raw dividend, returned as Hi on divide-by-zero
  logic [WIDTH-1:0] operandReg;  // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] qReg;        // multiplier shifting out / quotient shifting in
  logic [WIDTH:0]   accReg;      // product high half (+carry) or partial remainder
  logic [WIDTH-1:0] hiReg, loReg;
  logic             doneReg;

  logic             startOp, startMthi, startMtlo;
  logic             opSigned;
  logic [WIDTH-1:0] magIn1, magIn2;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divTrial;
  logic [WIDTH:0]   stepAcc;
  logic [WIDTH-1:0] stepQ;
  logic [2*WIDTH-1:0] product, fixProd;
  logic [WIDTH-1:0] quotient, remainder;
  logic [WIDTH-1:0] fixHi, fixLo;

  assign startOp   = (stateReg == IDLE) && Start && (MdOp[2] == 1'b0);
  assign startMthi = (stateReg == IDLE) && Start && (MdOp == 3'b100);
  assign startMtlo = (stateReg == IDLE) && Start && (MdOp == 3'b101);

  // Even MdOp codes (MULT, DIV) are the signed variants.
  assign opSigned = ~MdOp[0];
  assign magIn1   = (opSigned && DataIn1[WIDTH-1]) ? -DataIn1 : DataIn1;
  assign magIn2   = (opSigned && DataIn2[WIDTH-1]) ? -DataIn2 : DataIn2;

  // One iteration of shift-add multiply or restoring division.
  always_comb begin
    mulSum   = accReg + (qReg[0] ? {1'b0, operandReg} : {(WIDTH+1){1'b0}});
    divShift = {accReg[WIDTH-1:0], qReg[WIDTH-1]};
    divTrial = {1'b0, divShift} - {2'b00, operandReg};
    stepAcc  = accReg;
    stepQ    = qReg;
    if (isDivReg) begin
      // Trial subtraction without borrow means the divisor fits: keep it.
      if (!divTrial[WIDTH+1]) begin
        stepAcc = divTrial[WIDTH:0];
        stepQ   = {qReg[WIDTH-2:0], 1'b1};
      end else begin
        stepAcc = divShift;
        stepQ   = {qReg[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Shift the (carry, sum, multiplier) chain right by one.
      stepAcc = {1'b0, mulSum[WIDTH:1]};
      stepQ   = {mulSum[0], qReg[WIDTH-1:1]};
    end
  end

  // Sign correction applied in the FIX cycle.
  always_comb begin
    product   = {accReg[WIDTH-1:0], qReg};
    fixProd   = (negAReg ^ negBReg) ? -product : product;
    quotient  = (negAReg ^ negBReg) ? -qReg : qReg;
    // Remainder follows the dividend's sign.
    remainder = negAReg ? -accReg[WIDTH-1:0] : accReg[WIDTH-1:0];
    fixHi     = fixProd[2*WIDTH-1:WIDTH];
    fixLo     = fixProd[WIDTH-1:0];
    if (isDivReg) begin
      if (divZeroReg) begin
        fixHi = srcAReg;
        fixLo = '1;
      end else begin
        fixHi = remainder;
        fixLo = quotient;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (startOp) stateNext = CALC;
      CALC:    if (countReg == LAST_COUNT) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      countReg   <= '0;
      isDivReg   <= 1'b0;
      negAReg    <= 1'b0;
      negBReg    <= 1'b0;
      divZeroReg <= 1'b0;
      srcAReg    <= '0;
      operandReg <= '0;
      qReg       <= '0;
      accReg     <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (startOp) begin
            countReg   <= '0;
            isDivReg   <= MdOp[1];
            negAReg    <= opSigned && DataIn1[WIDTH-1];
            negBReg    <= opSigned && DataIn2[WIDTH-1];
            divZeroReg <= MdOp[1] && (DataIn2 == '0);
            srcAReg    <= DataIn1;
            accReg     <= '0;
            // Divide shifts the dividend through qReg; multiply shifts the multiplier.
            qReg       <= MdOp[1] ? magIn1 : magIn2;
            operandReg <= MdOp[1] ? magIn2 : magIn1;
          end
          if (startMthi) hiReg <= DataIn1;
          if (startMtlo) loReg <= DataIn1;
        end
        CALC: begin
          accReg   <= stepAcc;
          qReg     <= stepQ;
          countReg <= countReg + CW'(1);
        end
        FIX: begin
          hiReg   <= fixHi;
          loReg   <= fixLo;
          doneReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (stateReg != IDLE);
  assign Done = doneReg;
  assign Hi   = hiReg;
  assign Lo   = loReg;

endmodule
